nmr_vote_unit: RTL and testbench
================================

Name: nmr_vote_unit

Overview:
Parametrised N-modular-redundant voter for replicated datapath units (ALU, adder, regfile read ports). It takes N replica outputs, produces a registered majority result, and tracks disagreements per replica. A replica that disagrees too often is retired from future votes. The block sits between the replicated units and the consuming pipeline stage, and raises a sticky fatal flag when too few replicas remain active.

Parameters:
N, 8, replica count (3..16)
WIDTH, 32, data width per replica
CNT_W, 4, width of each per-replica fault counter
RETIRE_THRESH, 3, counter value at which a replica is retired (1..2^CNT_W-1)
CONSEC, 0, 1 = counter clears on an agreeing sample (counts consecutive faults only); 0 = cumulative
MIN_ACTIVE, 3, fatal asserts when the active replica count falls below this

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled at the rising edge of clk)
in_valid  input  1  replica_data holds a sample to vote this cycle
replica_data  input  N*WIDTH  replica i occupies bits [i*WIDTH +: WIDTH]
reinstate  input  N  per-replica request: re-enable the replica and clear its counter
out_valid  output  1  out_data and mismatch are valid this cycle
out_data  output  WIDTH  voted result
mismatch  output  N  replica i was active and disagreed with the voted result
active_mask  output  N  replicas currently participating in the vote
fault_count  output  N*CNT_W  per-replica counters, replica i at bits [i*CNT_W +: CNT_W]
fatal  output  1  sticky: active count dropped below MIN_ACTIVE

Behaviour:
- Reset (reset==0 at edge): out_valid=0, out_data=0, mismatch=0, active_mask=all ones, fault_count=0, fatal=0. Reset overrides in_valid and reinstate in the same cycle.
- Vote rule: combinational, per bit, over replicas with active_mask=1 only.
  - Bit = 1 if the number of active replicas with 1 exceeds the number with 0.
  - Bit = 0 if the number with 0 exceeds the number with 1.
  - Tie: take the bit from the lowest-index active replica.
  - Zero active replicas: vote result = 0.
- Latency: one cycle. When in_valid=1 at edge k, then at edge k+1 (visible the cycle after):
  - out_valid=1 and out_data=vote.
  - mismatch[i] = active[i] & (replica_i != vote).
  - When in_valid=0 at an edge, the next cycle has out_valid=0 and mismatch=0. out_data holds its last value.
- No backpressure: the block accepts one sample per cycle and never stalls.
- Counter update, only on an in_valid edge and only for replicas with active=1:
  - Mismatch: counter increments, saturating at 2^CNT_W-1.
  - Agreement with CONSEC=1: counter clears to 0.
  - Agreement with CONSEC=0: counter holds.
- Retire: if a replica's post-increment counter is >= RETIRE_THRESH, active[i] clears at the same edge. The retired replica is excluded from the next sample's vote. Counters of retired replicas freeze.
- Reinstate[i]=1 at an edge sets active[i]=1 and fault_count[i]=0. This takes priority over a simultaneous mismatch or retire on that replica. Reinstate of an already-active replica only clears its counter.
- Fatal: set at any edge where the popcount of the next active_mask is < MIN_ACTIVE. It stays set until reset; reinstate does not clear it. Voting continues while fatal=1.
- Multiple replicas may retire at the same edge.
- Timing of the retire decision: it uses the vote computed with the mask from before that edge, not the updated mask.

Decomposition:
- Shared package nmr_pkg:
  - popcount function.
  - Per-bit vote function taking (bits, mask) with the tie rule above.
  - Default parameter constants.
- Sub-module nmr_replica_tracker, instantiated N times. It holds one counter and one active bit, with these inputs:
  - sample strobe
  - mismatch
  - reinstate
  - CONSEC/RETIRE_THRESH parameters
- Voter datapath and fatal logic stay in the top module.

Test Plan:
1. Release reset; all 8 replicas = 0x1234_5678 with in_valid=1 for one cycle. Next cycle: out_valid=1, out_data=0x12345678, mismatch=0x00, active_mask=0xFF, all counts 0. The cycle after: out_valid=0.
2. Replica 5 = 0x1234_5679, others = 0x12345678, three consecutive samples. Each result = 0x12345678 and mismatch=0x20. count5 goes 1,2,3. active_mask=0xDF after the third edge. A fourth identical sample gives mismatch=0x00 and count5 stays 3.
3. CONSEC=1: replica 2 wrong, then right, then wrong. count2 goes 1,0,1. active_mask stays 0xFF.
4. Retire replicas 4..7 via repeated faults. Then replicas 0,1 = 0xFFFFFFFF and replicas 2,3 = 0x00000000. Result: out_data=0xFFFFFFFF (tie goes to lowest index), mismatch=0x0C.
5. Retire down to 2 active replicas: fatal=1 on the retiring edge. Then reinstate=0xFF: active_mask=0xFF, all counts 0, fatal still 1. A reset pulse then clears fatal.
6. reset=0 during a stream with in_valid=1 and reinstate=0x01. Next cycle: every output at its reset value, out_valid=0. The first sample after reset releases is voted normally.

Source files
------------

// File: rtl/nmr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nmr_pkg
//  Description : Shared constants and helper functions for the NMR voter
//                (population count and per-bit majority vote with tie rule).
//  Revision    : 1.0 - initial release
// ============================================================================
package nmr_pkg;

    // Largest supported replica count; helper functions work on this width
    localparam int MAX_N                 = 16;

    // Default parameter values for the voter
    localparam int DEFAULT_N             = 8;
    localparam int DEFAULT_WIDTH         = 32;
    localparam int DEFAULT_CNT_W         = 4;
    localparam int DEFAULT_RETIRE_THRESH = 3;
    localparam int DEFAULT_CONSEC        = 0;
    localparam int DEFAULT_MIN_ACTIVE    = 3;

    // Number of set bits in a replica-wide vector
    function automatic logic [4:0] popcount(input logic [MAX_N-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < MAX_N; i++) begin
            c = c + {4'b0000, v[i]};
        end
        return c;
    endfunction

    // Majority of the masked bits; a tie takes the lowest-index active bit,
    // and an empty mask yields 0 (tie with no active replica).
    function automatic logic vote_bit(input logic [MAX_N-1:0] bits,
                                      input logic [MAX_N-1:0] mask);
        logic [4:0] ones;
        logic [4:0] zeros;
        logic       tie_bit;
        logic       found;
        ones    = popcount(bits & mask);
        zeros   = popcount(~bits & mask);
        tie_bit = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < MAX_N; i++) begin
            if (mask[i] && !found) begin
                tie_bit = bits[i];
                found   = 1'b1;
            end
        end
        if (ones > zeros) begin
            return 1'b1;
        end else if (zeros > ones) begin
            return 1'b0;
        end
        return tie_bit;
    endfunction

endpackage : nmr_pkg
`default_nettype wire

// File: rtl/nmr_replica_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : nmr_replica_tracker
//  Description : Fault counter and active flag for one replica. Retires the
//                replica once its counter reaches the threshold.
//  Revision    : 1.0 - initial release
// ============================================================================
module nmr_replica_tracker
    import nmr_pkg::*;
#(
    parameter int CNT_W         = DEFAULT_CNT_W,
    parameter int RETIRE_THRESH = DEFAULT_RETIRE_THRESH,
    parameter int CONSEC        = DEFAULT_CONSEC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample,
    input  logic             mismatch,
    input  logic             reinstate,
    output logic             active,
    output logic             active_next,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] C_THRESH = CNT_W'(RETIRE_THRESH);
    localparam logic [CNT_W-1:0] C_MAX    = {CNT_W{1'b1}};

    logic             r_active;
    logic [CNT_W-1:0] r_count;
    logic             w_active_next;
    logic [CNT_W-1:0] w_count_next;
    logic [CNT_W-1:0] w_inc;

    // Next counter/flag: reinstate wins; retired replicas are frozen
    always_comb begin
        w_inc         = (r_count == C_MAX) ? r_count : r_count + CNT_W'(1);
        w_active_next = r_active;
        w_count_next  = r_count;
        if (reinstate) begin
            w_active_next = 1'b1;
            w_count_next  = '0;
        end else if (sample && r_active) begin
            if (mismatch) begin
                w_count_next = w_inc;
                if (w_inc >= C_THRESH) begin
                    w_active_next = 1'b0;
                end
            end else if (CONSEC != 0) begin
                w_count_next = '0;
            end
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_active <= 1'b1;
            r_count  <= '0;
        end else begin
            r_active <= w_active_next;
            r_count  <= w_count_next;
        end
    end

    assign active      = r_active;
    assign active_next = w_active_next;
    assign count       = r_count;

endmodule : nmr_replica_tracker
`default_nettype wire

// File: rtl/nmr_vote_unit.sv
`default_nettype none
// ============================================================================
//  Module      : nmr_vote_unit
//  Description : N-modular-redundant voter with per-replica fault tracking,
//                replica retirement and a sticky fatal flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module nmr_vote_unit
    import nmr_pkg::*;
#(
    parameter int N             = DEFAULT_N,
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int CNT_W         = DEFAULT_CNT_W,
    parameter int RETIRE_THRESH = DEFAULT_RETIRE_THRESH,
    parameter int CONSEC        = DEFAULT_CONSEC,
    parameter int MIN_ACTIVE    = DEFAULT_MIN_ACTIVE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [N*WIDTH-1:0]   replica_data,
    input  logic [N-1:0]         reinstate,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [N-1:0]         mismatch,
    output logic [N-1:0]         active_mask,
    output logic [N*CNT_W-1:0]   fault_count,
    output logic                 fatal
);

    logic [N-1:0]       w_active;
    logic [N-1:0]       w_active_nx;
    logic [MAX_N-1:0]   w_mask_ext;
    logic [MAX_N-1:0]   w_mask_nx_ext;
    logic [WIDTH-1:0]   w_vote;
    logic [N-1:0]       w_mis;
    logic               w_fatal_trip;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic [N-1:0]       r_mismatch;
    logic               r_fatal;

    // Widen current and next active masks to the helper-function width
    always_comb begin
        w_mask_ext             = '0;
        w_mask_nx_ext          = '0;
        w_mask_ext[N-1:0]      = w_active;
        w_mask_nx_ext[N-1:0]   = w_active_nx;
    end

    assign w_fatal_trip = int'(popcount(w_mask_nx_ext)) < MIN_ACTIVE;

    // Per-bit vote over the currently active replicas
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [MAX_N-1:0] w_col;
        // Gather bit b of every replica into one column
        always_comb begin
            w_col = '0;
            for (int i = 0; i < N; i++) begin
                w_col[i] = replica_data[i*WIDTH + b];
            end
        end
        assign w_vote[b] = vote_bit(w_col, w_mask_ext);
    end

    // Per-replica disagreement detection and fault tracking
    for (genvar i = 0; i < N; i++) begin : g_rep
        assign w_mis[i] = w_active[i] & (replica_data[i*WIDTH +: WIDTH] != w_vote);

        nmr_replica_tracker #(
            .CNT_W         (CNT_W),
            .RETIRE_THRESH (RETIRE_THRESH),
            .CONSEC        (CONSEC)
        ) u_tracker (
            .clk         (clk),
            .reset       (reset),
            .sample      (in_valid),
            .mismatch    (w_mis[i]),
            .reinstate   (reinstate[i]),
            .active      (w_active[i]),
            .active_next (w_active_nx[i]),
            .count       (fault_count[i*CNT_W +: CNT_W])
        );
    end

    // Registered vote result, mismatch vector and sticky fatal flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_mismatch  <= '0;
            r_fatal     <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            r_mismatch  <= in_valid ? w_mis : '0;
            if (in_valid) begin
                r_out_data <= w_vote;
            end
            if (w_fatal_trip) begin
                r_fatal <= 1'b1;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign mismatch    = r_mismatch;
    assign active_mask = w_active;
    assign fatal       = r_fatal;

endmodule : nmr_vote_unit
`default_nettype wire

// File: tb/tb_nmr_vote_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nmr_vote_unit
//  Description : Self-checking bench for nmr_vote_unit. Two instances share
//                stimulus: index 0 counts cumulatively, index 1 counts
//                consecutive faults only.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nmr_vote_unit;

    localparam int N      = 8;
    localparam int WIDTH  = 32;
    localparam int CNT_W  = 4;
    localparam int THRESH = 3;
    localparam int MIN_A  = 3;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic [N*WIDTH-1:0]   replica_bus;
    logic [N-1:0]         reinstate;

    logic [1:0]           ov;
    logic [WIDTH-1:0]     od   [2];
    logic [N-1:0]         mis  [2];
    logic [N-1:0]         am   [2];
    logic [N*CNT_W-1:0]   fc   [2];
    logic [1:0]           fat;

    logic [WIDTH-1:0]     rep  [N];

    // reference model state, one copy per instance
    int                   m_act [2][N];
    int                   m_cnt [2][N];
    bit                   m_fatal [2];
    bit                   m_ov;
    logic [WIDTH-1:0]     m_od  [2];
    logic [N-1:0]         m_mis [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // pack replica words onto the DUT bus
    always_comb begin
        replica_bus = '0;
        for (int i = 0; i < N; i++) replica_bus[i*WIDTH +: WIDTH] = rep[i];
    end

    nmr_vote_unit #(.N(N), .WIDTH(WIDTH), .CNT_W(CNT_W), .RETIRE_THRESH(THRESH),
                    .CONSEC(0), .MIN_ACTIVE(MIN_A)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .replica_data(replica_bus),
        .reinstate(reinstate), .out_valid(ov[0]), .out_data(od[0]), .mismatch(mis[0]),
        .active_mask(am[0]), .fault_count(fc[0]), .fatal(fat[0]));

    nmr_vote_unit #(.N(N), .WIDTH(WIDTH), .CNT_W(CNT_W), .RETIRE_THRESH(THRESH),
                    .CONSEC(1), .MIN_ACTIVE(MIN_A)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .replica_data(replica_bus),
        .reinstate(reinstate), .out_valid(ov[1]), .out_data(od[1]), .mismatch(mis[1]),
        .active_mask(am[1]), .fault_count(fc[1]), .fatal(fat[1]));

    // Majority vote by counting ones and zeros among active replicas
    function automatic logic [WIDTH-1:0] ref_vote(input int d);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int b = 0; b < WIDTH; b++) begin
            int ones = 0, zeros = 0, first = -1;
            for (int i = 0; i < N; i++) begin
                if (m_act[d][i] != 0) begin
                    if (rep[i][b]) ones++; else zeros++;
                    if (first < 0) first = i;
                end
            end
            if (ones > zeros)       r[b] = 1'b1;
            else if (zeros > ones)  r[b] = 1'b0;
            else if (first >= 0)    r[b] = rep[first][b];
            else                    r[b] = 1'b0;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                m_act[d][i] = 1;
                m_cnt[d][i] = 0;
            end
            m_fatal[d] = 0;
            m_od[d]    = '0;
            m_mis[d]   = '0;
        end
        m_ov = 0;
    endtask

    task automatic model_edge(input bit v, input bit [N-1:0] rn, input bit rst_n);
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            logic [WIDTH-1:0] vt;
            logic [N-1:0]     mv;
            int               pop;
            vt = ref_vote(d);
            mv = '0;
            for (int i = 0; i < N; i++) begin
                mv[i] = (m_act[d][i] != 0) && (rep[i] != vt);
                if (rn[i]) begin
                    m_act[d][i] = 1;
                    m_cnt[d][i] = 0;
                end else if (v && m_act[d][i] != 0) begin
                    if (mv[i]) begin
                        if (m_cnt[d][i] < CMAX) m_cnt[d][i]++;
                        if (m_cnt[d][i] >= THRESH) m_act[d][i] = 0;
                    end else if (d == 1) begin
                        m_cnt[d][i] = 0;
                    end
                end
            end
            pop = 0;
            for (int i = 0; i < N; i++) pop += m_act[d][i];
            if (pop < MIN_A) m_fatal[d] = 1;
            if (v) m_od[d] = vt;
            m_mis[d] = v ? mv : '0;
        end
        m_ov = v;
    endtask

    task automatic chk(input string tag, input int d, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, d, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            logic [N-1:0]       em;
            logic [N*CNT_W-1:0] ec;
            for (int i = 0; i < N; i++) begin
                em[i] = (m_act[d][i] != 0);
                ec[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[d][i]);
            end
            chk("out_valid",   d, 64'(ov[d]),  64'(m_ov));
            chk("out_data",    d, 64'(od[d]),  64'(m_od[d]));
            chk("mismatch",    d, 64'(mis[d]), 64'(m_mis[d]));
            chk("active_mask", d, 64'(am[d]),  64'(em));
            chk("fault_count", d, 64'(fc[d]),  64'(ec));
            chk("fatal",       d, 64'(fat[d]), 64'(m_fatal[d]));
        end
    endtask

    // Apply one cycle of stimulus, advance the model, check after the edge
    task automatic step(input bit v, input bit [N-1:0] rn, input bit rst_n);
        in_valid  = v;
        reinstate = rn;
        reset     = rst_n;
        model_edge(v, rn, rst_n);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_all(input logic [WIDTH-1:0] val);
        for (int i = 0; i < N; i++) rep[i] = val;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; reinstate = '0;
        set_all('0);
        model_reset();

        // reset state
        step(0, 8'h00, 0);
        step(1, 8'h00, 0);

        // all replicas agree, then idle
        set_all(32'h1234_5678);
        step(1, 8'h00, 1);
        step(0, 8'h00, 1);

        // replica 5 off by one: three faults retire it, fourth sample is quiet
        rep[5] = 32'h1234_5679;
        repeat (4) step(1, 8'h00, 1);
        step(0, 8'hFF, 1);

        // replica 2 wrong, right, wrong
        set_all(32'h1234_5678);
        rep[2] = 32'hDEAD_BEEF; step(1, 8'h00, 1);
        rep[2] = 32'h1234_5678; step(1, 8'h00, 1);
        rep[2] = 32'hDEAD_BEEF; step(1, 8'h00, 1);
        step(0, 8'hFF, 1);

        // retire replicas 4..7 (4-4 tie resolved by replica 0)
        set_all(32'h1234_5678);
        for (int i = 4; i < N; i++) rep[i] = 32'h0BAD_F00D;
        repeat (3) step(1, 8'h00, 1);
        // 2-2 tie among the survivors goes to replica 0
        rep[0] = 32'hFFFF_FFFF; rep[1] = 32'hFFFF_FFFF;
        rep[2] = 32'h0000_0000; rep[3] = 32'h0000_0000;
        step(1, 8'h00, 1);
        // keep faulting 2,3 until only two remain -> fatal
        repeat (2) step(1, 8'h00, 1);
        step(1, 8'h00, 1);
        // reinstate all: mask restored, fatal stays
        step(0, 8'hFF, 1);
        step(0, 8'h00, 0);
        step(0, 8'h00, 1);

        // reset in the middle of a stream with a reinstate request
        set_all(32'hCAFE_0001);
        rep[7] = 32'hCAFE_0002;
        step(1, 8'h00, 1);
        step(1, 8'h01, 0);
        step(1, 8'h00, 1);
        step(0, 8'h00, 1);

        // randomized traffic
        for (int t = 0; t < 300; t++) begin
            logic [WIDTH-1:0] base;
            bit [N-1:0]       rn;
            base = WIDTH'($urandom);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0)
                    rep[i] = base ^ (32'h1 << $urandom_range(0, 31));
                else
                    rep[i] = base;
            end
            rn = ($urandom_range(0, 9) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
            step($urandom_range(0, 4) != 0, rn, $urandom_range(0, 99) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule : tb_nmr_vote_unit
`default_nettype wire
